// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART transmit arbiter.
// Imported by the arbiter top module.
package uart_pkg;

   localparam logic [7:0] STX = 8'h02;
   localparam logic [7:0] ETX = 8'h03;
   localparam logic [15:0] TIMEOUT_DEFAULT = 16'd50000;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SEND,
      WAIT_ACK,
      HOLD,
      RELEASE
   } state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle of the UART arbiter.
// master is the arbiter side, slave is the environment side.
interface uart_tx_arbiter_if;

   logic [1:0] req;
   logic [7:0] req_data0;
   logic [7:0] req_data1;
   logic [1:0] ack;
   logic       tx_req;
   logic [7:0] tx_data;
   logic       tx_ack;
   logic       owner;
   logic       busy;
   logic       ovf_err;
   logic       timeout_err;

   modport master (
      input  req, req_data0, req_data1, tx_ack,
      output ack, tx_req, tx_data, owner, busy,
      output ovf_err, timeout_err
   );

   modport slave (
      output req, req_data0, req_data1, tx_ack,
      input  ack, tx_req, tx_data, owner, busy,
      input  ovf_err, timeout_err
   );

endinterface

// File: rtl/uart_req_slot.sv
// Single-entry byte slot for one requester.
// Drops a byte arriving while full, except in the cycle the slot is cleared.
module uart_req_slot (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic       clr,
   input  logic [7:0] din,
   output logic       pend,
   output logic [7:0] data,
   output logic       ovf
);

   always_ff @(posedge clk) begin
      if (rst) begin
         pend <= 1'b0;
         data <= 8'h00;
         ovf  <= 1'b0;
      end else begin
         ovf <= req && pend && !clr;
         if (req && (!pend || clr)) begin
            pend <= 1'b1;
            data <= din;
         end else if (clr) begin
            pend <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester frame arbiter in front of a shared UART transmitter.
// A grant is held until ETX is sent or the owner goes quiet too long.
module uart_tx_arbiter #(
   parameter logic [7:0]  ETX     = uart_pkg::ETX,
   parameter logic [15:0] TIMEOUT = uart_pkg::TIMEOUT_DEFAULT
) (
   input logic                clk,
   input logic                rst,
   uart_tx_arbiter_if.master  bus
);

   import uart_pkg::*;

   state_t      state;
   logic [1:0]  pend;
   logic [1:0]  clr;
   logic [1:0]  ovf;
   logic [7:0]  data0;
   logic [7:0]  data1;
   logic [7:0]  tx_data_q;
   logic        tx_req_q;
   logic [1:0]  ack_q;
   logic        owner_q;
   logic        last_grant;
   logic [15:0] cnt;
   logic        to_q;

   assign clr[0] = (state == LOAD) && !owner_q;
   assign clr[1] = (state == LOAD) && owner_q;

   uart_req_slot u_slot0 (
      .clk  (clk),
      .rst  (rst),
      .req  (bus.req[0]),
      .clr  (clr[0]),
      .din  (bus.req_data0),
      .pend (pend[0]),
      .data (data0),
      .ovf  (ovf[0])
   );

   uart_req_slot u_slot1 (
      .clk  (clk),
      .rst  (rst),
      .req  (bus.req[1]),
      .clr  (clr[1]),
      .din  (bus.req_data1),
      .pend (pend[1]),
      .data (data1),
      .ovf  (ovf[1])
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         tx_data_q  <= STX;
         tx_req_q   <= 1'b0;
         ack_q      <= 2'b00;
         owner_q    <= 1'b0;
         last_grant <= 1'b1;
         cnt        <= 16'd0;
         to_q       <= 1'b0;
      end else begin
         tx_req_q <= 1'b0;
         ack_q    <= 2'b00;
         to_q     <= 1'b0;
         unique case (state)
            IDLE: begin
               if (|pend) begin
                  owner_q <= (&pend) ? ~last_grant : pend[1];
                  state   <= LOAD;
               end
            end
            LOAD: begin
               tx_data_q <= owner_q ? data1 : data0;
               tx_req_q  <= 1'b1;
               state     <= SEND;
            end
            SEND: state <= WAIT_ACK;
            WAIT_ACK: begin
               if (bus.tx_ack) begin
                  ack_q[owner_q] <= 1'b1;
                  cnt            <= 16'd0;
                  state <= (tx_data_q == ETX) ? RELEASE : HOLD;
               end
            end
            // only the owner's slot is looked at: no preemption
            HOLD: begin
               if (pend[owner_q]) begin
                  state <= LOAD;
               end else if (cnt == TIMEOUT - 16'd1) begin
                  to_q  <= 1'b1;
                  state <= RELEASE;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            RELEASE: begin
               last_grant <= owner_q;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ack         = ack_q;
   assign bus.tx_req      = tx_req_q;
   assign bus.tx_data     = tx_data_q;
   assign bus.owner       = owner_q;
   assign bus.busy        = (state != IDLE);
   assign bus.ovf_err     = |ovf;
   assign bus.timeout_err = to_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: frames, contention, atomicity,
// overflow, timeout and reset abort, with hand-written expected bytes.
module tb_uart_tx_arbiter;

   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0;
   logic rst = 1'b1;

   uart_tx_arbiter_if bus ();

   uart_tx_arbiter #(
      .ETX     (8'h03),
      .TIMEOUT (16'd16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_err    = 0;
   int   n_ack0   = 0;
   int   n_ack1   = 0;
   int   n_ovf    = 0;
   int   n_to     = 0;
   bit   auto_ack = 1'b1;
   bq_t  sent_q;
   bq_t  own_q;
   bq_t  exp_q;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic check_seq(input string tag, input bq_t got, input bq_t e);
      check({tag, "_len"}, got.size(), e.size());
      for (int i = 0; i < e.size() && i < got.size(); i++)
         check($sformatf("%s[%0d]", tag, i), got[i], e[i]);
   endtask

   // monitor: every byte handed to the transmitter and every pulse
   initial forever begin
      @(negedge clk);
      if (bus.tx_req) begin
         sent_q.push_back(bus.tx_data);
         own_q.push_back({7'd0, bus.owner});
      end
      if (bus.ack[0]) n_ack0++;
      if (bus.ack[1]) n_ack1++;
      if (bus.ovf_err) n_ovf++;
      if (bus.timeout_err) n_to++;
   end

   // transmitter model: ack two cycles after tx_req
   initial forever begin
      @(negedge clk);
      if (bus.tx_req && auto_ack) begin
         @(negedge clk);
         @(negedge clk);
         bus.tx_ack = 1'b1;
         @(negedge clk);
         bus.tx_ack = 1'b0;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      rst = 1'b1;
      bus.req = 2'b00;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_byte(input int i, input logic [7:0] d);
      if (i == 0) bus.req_data0 = d;
      else bus.req_data1 = d;
      bus.req[i] = 1'b1;
      @(negedge clk);
      bus.req = 2'b00;
   endtask

   task automatic wait_ack(input int i, input string tag);
      bit found = 1'b0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (bus.ack[i]) begin
            found = 1'b1;
            break;
         end
      end
      check({tag, "_ack_seen"}, found, 1);
   endtask

   task automatic settle();
      repeat (4) @(negedge clk);
      sent_q.delete();
      own_q.delete();
   endtask

   initial begin
      int lat;
      int a0;
      int o0;
      int t0;
      int s0;
      bit seen;
      bus.req = 2'b00;
      bus.req_data0 = 8'h00;
      bus.req_data1 = 8'h00;
      bus.tx_ack = 1'b0;

      // reset state
      do_reset();
      check("rst_busy", bus.busy, 0);
      check("rst_txdata", bus.tx_data, 8'h02);
      check("rst_txreq", bus.tx_req, 0);
      check("rst_ack", bus.ack, 0);
      check("rst_owner", bus.owner, 0);
      check("rst_ovf", bus.ovf_err, 0);
      check("rst_to", bus.timeout_err, 0);

      // single frame with first-byte latency
      a0 = n_ack0;
      bus.req_data0 = 8'h02;
      bus.req[0] = 1'b1;
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         bus.req = 2'b00;
         if (bus.tx_req) begin
            lat = k;
            break;
         end
      end
      check("latency", lat, 3);
      wait_ack(0, "f1b0");
      send_byte(0, 8'h31);
      wait_ack(0, "f1b1");
      send_byte(0, 8'h35);
      wait_ack(0, "f1b2");
      send_byte(0, 8'h03);
      wait_ack(0, "f1b3");
      repeat (2) @(negedge clk);
      check("f1_busy", bus.busy, 0);
      check("f1_acks", n_ack0 - a0, 4);
      exp_q = {8'h02, 8'h31, 8'h35, 8'h03};
      check_seq("f1_seq", sent_q, exp_q);
      settle();

      // contention: 0 wins after reset, then 1 wins the re-contention
      do_reset();
      sent_q.delete();
      own_q.delete();
      bus.req_data0 = 8'h02;
      bus.req_data1 = 8'h12;
      bus.req = 2'b11;
      @(negedge clk);
      bus.req = 2'b00;
      wait_ack(0, "c0b0");
      send_byte(0, 8'h03);
      wait_ack(0, "c0b1");
      send_byte(0, 8'h05);
      wait_ack(1, "c1b0");
      send_byte(1, 8'h03);
      wait_ack(1, "c1b1");
      wait_ack(0, "c2b0");
      send_byte(0, 8'h03);
      wait_ack(0, "c2b1");
      exp_q = {8'h02, 8'h03, 8'h12, 8'h03, 8'h05, 8'h03};
      check_seq("cont_seq", sent_q, exp_q);
      exp_q = {8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00};
      check_seq("cont_own", own_q, exp_q);
      settle();

      // atomicity: requester 1 waits for requester 0's ETX
      send_byte(0, 8'h02);
      wait_ack(0, "atb0");
      send_byte(1, 8'h41);
      send_byte(0, 8'h31);
      wait_ack(0, "atb1");
      send_byte(0, 8'h03);
      wait_ack(0, "atb2");
      wait_ack(1, "atb3");
      send_byte(1, 8'h03);
      wait_ack(1, "atb4");
      exp_q = {8'h02, 8'h31, 8'h03, 8'h41, 8'h03};
      check_seq("atom_seq", sent_q, exp_q);
      exp_q = {8'h00, 8'h00, 8'h00, 8'h01, 8'h01};
      check_seq("atom_own", own_q, exp_q);
      settle();

      // overflow: second byte into a full slot is dropped
      o0 = n_ovf;
      send_byte(0, 8'h02);
      wait_ack(0, "ovb0");
      send_byte(1, 8'hAA);
      @(negedge clk);
      send_byte(1, 8'hBB);
      repeat (2) @(negedge clk);
      check("ovf_pulses", n_ovf - o0, 1);
      send_byte(0, 8'h03);
      wait_ack(0, "ovb1");
      wait_ack(1, "ovb2");
      send_byte(1, 8'h03);
      wait_ack(1, "ovb3");
      exp_q = {8'h02, 8'h03, 8'hAA, 8'h03};
      check_seq("ovf_seq", sent_q, exp_q);
      settle();

      // timeout: owner 0 goes quiet, pending requester 1 takes over
      do_reset();
      sent_q.delete();
      own_q.delete();
      t0 = n_to;
      bus.req_data0 = 8'h02;
      bus.req_data1 = 8'h55;
      bus.req = 2'b11;
      @(negedge clk);
      bus.req = 2'b00;
      wait_ack(0, "tob0");
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (bus.timeout_err) begin
            lat = k;
            break;
         end
      end
      check("to_cycles", lat, 16);
      wait_ack(1, "tob1");
      check("to_owner", bus.owner, 1);
      send_byte(1, 8'h03);
      wait_ack(1, "tob2");
      check("to_pulses", n_to - t0, 1);
      exp_q = {8'h02, 8'h55, 8'h03};
      check_seq("to_seq", sent_q, exp_q);
      settle();

      // reset in WAIT_ACK aborts the frame and drops pending bytes
      auto_ack = 1'b0;
      send_byte(1, 8'h31);
      send_byte(0, 8'h44);
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (bus.tx_req) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("ra_txreq_seen", seen, 1);
      @(negedge clk);
      check("ra_pre_owner", bus.owner, 1);
      rst = 1'b1;
      @(negedge clk);
      check("ra_busy", bus.busy, 0);
      check("ra_txdata", bus.tx_data, 8'h02);
      check("ra_txreq", bus.tx_req, 0);
      check("ra_ack", bus.ack, 0);
      check("ra_owner", bus.owner, 0);
      rst = 1'b0;
      a0 = n_ack0 + n_ack1;
      s0 = sent_q.size();
      bus.tx_ack = 1'b1;
      @(negedge clk);
      bus.tx_ack = 1'b0;
      repeat (12) @(negedge clk);
      check("ra_late_ack", n_ack0 + n_ack1 - a0, 0);
      check("ra_no_txreq", sent_q.size() - s0, 0);
      check("ra_idle", bus.busy, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
